// File: rtl/wb_regfile_scoreboard.sv
// rtl/wb_regfile_scoreboard.sv - writeback GPR file with bypassed read ports and pending-write scoreboard
module wb_regfile_scoreboard #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_regwrite,
  input  logic          wb_memtoreg,
  input  logic [AW-1:0] wb_wn,
  input  logic [DW-1:0] wb_cal_data,
  input  logic [DW-1:0] wb_rd_data,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic          rs_used,
  input  logic          rt_used,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_wn,
  output logic          stall,
  output logic          sb_err
);

  localparam int NREG = 1 << AW;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DW-1:0]    gpr [NREG];
  logic [CNT_W-1:0] cnt [NREG];

  logic [DW-1:0]    wb_data;
  logic             wb_we;
  logic             accept;
  logic [NREG-1:0]  acc_vec;
  logic [NREG-1:0]  ret_vec;
  logic             same_reg;
  logic             ovf_evt;
  logic             unf_evt;
  logic             err_evt;

  logic [CNT_W-1:0] rs_cnt;
  logic [CNT_W-1:0] rt_cnt;
  logic             rs_ret;
  logic             rt_ret;
  logic             rs_busy;
  logic             rt_busy;

  // Writeback data select; register 0 never takes a write
  assign wb_data = wb_memtoreg ? wb_rd_data : wb_cal_data;
  assign wb_we   = wb_regwrite && (wb_wn != '0);

  // Read ports: zero register, then write-through bypass, then stored value
  assign rs_data = (rs_addr == '0) ? '0 :
                   (wb_we && (wb_wn == rs_addr)) ? wb_data : gpr[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 :
                   (wb_we && (wb_wn == rt_addr)) ? wb_data : gpr[rt_addr];

  // A source is busy if writes remain pending after this cycle's retirement;
  // an underflowing retire leaves nothing pending rather than wrapping
  always_comb begin
    rs_cnt  = cnt[rs_addr];
    rt_cnt  = cnt[rt_addr];
    rs_ret  = wb_we && (wb_wn == rs_addr);
    rt_ret  = wb_we && (wb_wn == rt_addr);
    rs_busy = rs_used && (rs_addr != '0) && (rs_cnt != CNT_ZERO) &&
              !(rs_ret && (rs_cnt == CNT_ONE));
    rt_busy = rt_used && (rt_addr != '0) && (rt_cnt != CNT_ZERO) &&
              !(rt_ret && (rt_cnt == CNT_ONE));
    stall   = rs_busy || rt_busy;
  end

  // One-hot issue/retire masks and scoreboard error detection for this cycle
  always_comb begin
    accept   = issue_valid && (issue_wn != '0) && !stall;
    acc_vec  = {NREG{accept}} & (NREG'(1) << issue_wn);
    ret_vec  = {NREG{wb_we}}  & (NREG'(1) << wb_wn);
    same_reg = accept && wb_we && (issue_wn == wb_wn);
    ovf_evt  = accept && !same_reg && (cnt[issue_wn] == CNT_MAX);
    unf_evt  = wb_we  && !same_reg && (cnt[wb_wn] == CNT_ZERO);
    err_evt  = ovf_evt || unf_evt;
  end

  // GPR storage; entry 0 stays zero because wb_we excludes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wb_we) begin
      gpr[wb_wn] <= wb_data;
    end
  end

  // Pending-write counters: issue increments, retire decrements, both cancel;
  // saturate at the ends instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (acc_vec[r] && !ret_vec[r]) begin
          if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + CNT_ONE;
        end else if (ret_vec[r] && !acc_vec[r]) begin
          if (cnt[r] != CNT_ZERO) cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if (err_evt) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// tb/tb_wb_regfile_scoreboard.sv - self-checking bench for wb_regfile_scoreboard
module tb_wb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        wb_regwrite;
  logic        wb_memtoreg;
  logic [4:0]  wb_wn;
  logic [31:0] wb_cal_data;
  logic [31:0] wb_rd_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_used;
  logic        rt_used;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        issue_valid;
  logic [4:0]  issue_wn;
  logic        stall;
  logic        sb_err;

  logic [31:0] m_gpr [32];
  int          m_cnt [32];
  bit          m_err;
  int          checks;
  int          errors;

  wb_regfile_scoreboard #(.DW(32), .AW(5), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_wn(wb_wn),
    .wb_cal_data(wb_cal_data), .wb_rd_data(wb_rd_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .rs_data(rs_data), .rt_data(rt_data),
    .issue_valid(issue_valid), .issue_wn(issue_wn),
    .stall(stall), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_wbdata();
    return wb_memtoreg ? wb_rd_data : wb_cal_data;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_regwrite && wb_wn == a) return m_wbdata();
    return m_gpr[a];
  endfunction

  function automatic bit m_busy(input logic used, input logic [4:0] a);
    int p;
    if (!used || a == 5'd0) return 1'b0;
    p = m_cnt[a];
    if (wb_regwrite && wb_wn == a) p = p - 1;
    if (p < 0) p = 0;
    return p != 0;
  endfunction

  function automatic bit m_stall();
    return m_busy(rs_used, rs_addr) || m_busy(rt_used, rt_addr);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_gpr[i] = 32'd0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic m_commit();
    bit acc, ret;
    acc = issue_valid && issue_wn != 5'd0 && !m_stall();
    ret = wb_regwrite && wb_wn != 5'd0;
    if (ret) m_gpr[wb_wn] = m_wbdata();
    if (!(acc && ret && issue_wn == wb_wn)) begin
      if (acc) begin
        if (m_cnt[issue_wn] == 3) m_err = 1'b1;
        else m_cnt[issue_wn] = m_cnt[issue_wn] + 1;
      end
      if (ret) begin
        if (m_cnt[wb_wn] == 0) m_err = 1'b1;
        else m_cnt[wb_wn] = m_cnt[wb_wn] - 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/rs_data"}, rs_data, m_read(rs_addr));
    check({tag, "/rt_data"}, rt_data, m_read(rt_addr));
    check({tag, "/stall"}, 32'(stall), 32'(m_stall()));
    check({tag, "/sb_err"}, 32'(sb_err), 32'(m_err));
  endtask

  task automatic idle();
    wb_regwrite = 1'b0; wb_memtoreg = 1'b0; wb_wn = 5'd0;
    wb_cal_data = 32'd0; wb_rd_data = 32'd0;
    rs_addr = 5'd0; rt_addr = 5'd0; rs_used = 1'b0; rt_used = 1'b0;
    issue_valid = 1'b0; issue_wn = 5'd0;
  endtask

  task automatic tick();
    m_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    m_reset();
    #2;
    check("reset/stall", 32'(stall), 32'd0);
    check("reset/sb_err", 32'(sb_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    #2 check_all("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset contents of every register on both ports, with sources marked used
    for (int i = 0; i < 32; i++) begin
      idle();
      rs_addr = 5'(i); rt_addr = 5'(31 - i); rs_used = 1'b1; rt_used = 1'b1;
      #2 check("reset_rs", rs_data, 32'd0);
      check_all("reset_scan");
      tick();
    end

    // Write to register 0 is dropped and is not a scoreboard underflow
    idle();
    wb_regwrite = 1'b1; wb_wn = 5'd0; wb_cal_data = 32'hFFFF_FFFF;
    tick();
    idle();
    rs_used = 1'b1;
    #2 check("t3_r0", rs_data, 32'd0);
    check("t3_err", 32'(sb_err), 32'd0);
    check("t3_stall", 32'(stall), 32'd0);
    check_all("t3");
    tick();

    // ALU writeback to r5, read next cycle
    idle();
    wb_regwrite = 1'b1; wb_wn = 5'd5; wb_memtoreg = 1'b0;
    wb_cal_data = 32'hDEAD_BEEF; wb_rd_data = $urandom;
    tick();
    idle();
    rs_addr = 5'd5;
    #2 check("t1_rs", rs_data, 32'hDEAD_BEEF);
    check_all("t1");
    tick();

    // Same-cycle bypass of load data
    idle();
    wb_regwrite = 1'b1; wb_wn = 5'd7; wb_memtoreg = 1'b1;
    wb_rd_data = 32'h0000_1234; wb_cal_data = $urandom;
    rt_addr = 5'd7;
    #2 check("t2_bypass", rt_data, 32'h0000_1234);
    check_all("t2");
    tick();

    do_reset();

    // RAW hazard on r3 held until its writeback arrives
    idle();
    issue_valid = 1'b1; issue_wn = 5'd3;
    #2 check_all("t4_issue");
    tick();
    for (int k = 0; k < 3; k++) begin
      idle();
      rs_addr = 5'd3; rs_used = 1'b1;
      #2 check("t4_hold", 32'(stall), 32'd1);
      check_all("t4_hold");
      tick();
    end
    idle();
    rs_addr = 5'd3; rs_used = 1'b1;
    wb_regwrite = 1'b1; wb_wn = 5'd3; wb_cal_data = 32'h0BAD_F00D;
    #2 check("t4_release", 32'(stall), 32'd0);
    check("t4_fwd", rs_data, 32'h0BAD_F00D);
    check_all("t4_release");
    tick();
    idle();
    rs_addr = 5'd3; rs_used = 1'b1;
    #2 check("t4_after", 32'(stall), 32'd0);
    check_all("t4_after");
    tick();

    // Saturation of r9 pending count at 3
    for (int k = 0; k < 4; k++) begin
      idle();
      issue_valid = 1'b1; issue_wn = 5'd9;
      #2 check("t5_err_pre", 32'(sb_err), 32'd0);
      check_all("t5_issue");
      tick();
    end
    idle();
    #2 check("t5_err", 32'(sb_err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      idle();
      rs_addr = 5'd9; rs_used = 1'b1;
      wb_regwrite = 1'b1; wb_wn = 5'd9; wb_cal_data = $urandom;
      #2 check("t5_drain", 32'(stall), (k < 2) ? 32'd1 : 32'd0);
      check_all("t5_drain");
      tick();
    end

    // Issue and retire of r4 in the same cycle cancel out
    idle();
    issue_valid = 1'b1; issue_wn = 5'd4;
    tick();
    idle();
    issue_valid = 1'b1; issue_wn = 5'd4;
    wb_regwrite = 1'b1; wb_wn = 5'd4; wb_cal_data = 32'h0000_4444;
    #2 check_all("t6_cancel");
    tick();
    idle();
    rs_addr = 5'd4; rs_used = 1'b1;
    #2 check("t6_pending", 32'(stall), 32'd1);
    check("t6_data", rs_data, 32'h0000_4444);
    check_all("t6_pending");
    rst_n = 1'b0;
    m_reset();
    #1 check("t6_rst_stall", 32'(stall), 32'd0);
    check("t6_rst_err", 32'(sb_err), 32'd0);
    check("t6_rst_gpr", rs_data, 32'd0);
    rs_addr = 5'd5;
    #1 check("t6_rst_r5", rs_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Randomized traffic over a narrow register window to force collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      wb_regwrite = ($urandom_range(0, 9) < 4);
      wb_memtoreg = $urandom_range(0, 1);
      wb_wn       = 5'($urandom_range(0, 7));
      wb_cal_data = $urandom;
      wb_rd_data  = $urandom;
      rs_addr     = 5'($urandom_range(0, 7));
      rt_addr     = 5'($urandom_range(0, 7));
      rs_used     = $urandom_range(0, 1);
      rt_used     = $urandom_range(0, 1);
      issue_valid = ($urandom_range(0, 9) < 5);
      issue_wn    = 5'($urandom_range(0, 7));
      #2 check_all("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
